// File: rtl/painter_pkg.sv
// painter_pkg: shared types and default geometry for the painter_multi block.
//   paint_mode_t    - FILL disc or RING
//   painter_state_t - sequencing FSM states
//   *_DEF           - default widths and screen size
package painter_pkg;

  localparam int H_WIDTH_DEF     = 11;
  localparam int V_WIDTH_DEF     = 10;
  localparam int R_WIDTH_DEF     = 8;
  localparam int COLOR_WIDTH_DEF = 16;
  localparam int H_MAX_DEF       = 1280;
  localparam int V_MAX_DEF       = 720;

  typedef enum logic {
    FILL = 1'b0,
    RING = 1'b1
  } paint_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } painter_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/painter_multi_if.sv
// painter_multi_if: request / pixel / status bundle of painter_multi.
//   slave  - painter side (takes requests, produces pixels, done, count)
//   master - client side (issues requests, consumes pixels)
import painter_pkg::*;

interface painter_multi_if #(
  parameter int H_WIDTH     = H_WIDTH_DEF,
  parameter int V_WIDTH     = V_WIDTH_DEF,
  parameter int R_WIDTH     = R_WIDTH_DEF,
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF
);
  logic                   data_valid_in;
  logic                   ready_out;
  logic [H_WIDTH-1:0]     hcount_in;
  logic [V_WIDTH-1:0]     vcount_in;
  logic [R_WIDTH-1:0]     radius_in;
  logic [R_WIDTH-1:0]     thickness_in;
  logic                   mode_in;
  logic [COLOR_WIDTH-1:0] color_in;
  logic [H_WIDTH-1:0]     hcount_out;
  logic [V_WIDTH-1:0]     vcount_out;
  logic [COLOR_WIDTH-1:0] color_out;
  logic                   data_valid_out;
  logic                   ready_in;
  logic                   done_out;
  logic [15:0]            shape_count_out;

  modport slave (
    input  data_valid_in, hcount_in, vcount_in, radius_in, thickness_in,
           mode_in, color_in, ready_in,
    output ready_out, hcount_out, vcount_out, color_out, data_valid_out,
           done_out, shape_count_out
  );

  modport master (
    output data_valid_in, hcount_in, vcount_in, radius_in, thickness_in,
           mode_in, color_in, ready_in,
    input  ready_out, hcount_out, vcount_out, color_out, data_valid_out,
           done_out, shape_count_out
  );
endinterface

// File: rtl/painter_multi_sq_dist.sv
// sq_dist: S1 stage of the painter pipeline. Registers |dx|^2 and |dy|^2
// together with the candidate coordinate; holds everything while stall_i.
//   clk_in, rst_in     - clock, synchronous active-high reset
//   stall_i            - hold stage contents
//   valid_i            - S0 holds a candidate
//   adx_i, ady_i       - unsigned distance to centre (fits R_WIDTH inside the box)
//   x_i, y_i           - candidate coordinate
//   valid_o, dx_sq_o, dy_sq_o, x_o, y_o - registered stage contents
import painter_pkg::*;

module sq_dist #(
  parameter int R_WIDTH = R_WIDTH_DEF,
  parameter int H_WIDTH = H_WIDTH_DEF,
  parameter int V_WIDTH = V_WIDTH_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   stall_i,
  input  logic                   valid_i,
  input  logic [R_WIDTH-1:0]     adx_i,
  input  logic [R_WIDTH-1:0]     ady_i,
  input  logic [H_WIDTH-1:0]     x_i,
  input  logic [V_WIDTH-1:0]     y_i,
  output logic                   valid_o,
  output logic [2*R_WIDTH-1:0]   dx_sq_o,
  output logic [2*R_WIDTH-1:0]   dy_sq_o,
  output logic [H_WIDTH-1:0]     x_o,
  output logic [V_WIDTH-1:0]     y_o
);
  logic                 valid_q;
  logic [2*R_WIDTH-1:0] dx_sq_q, dy_sq_q;
  logic [H_WIDTH-1:0]   x_q;
  logic [V_WIDTH-1:0]   y_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      dx_sq_q <= '0;
      dy_sq_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (!stall_i) begin
      valid_q <= valid_i;
      dx_sq_q <= {{R_WIDTH{1'b0}}, adx_i} * {{R_WIDTH{1'b0}}, adx_i};
      dy_sq_q <= {{R_WIDTH{1'b0}}, ady_i} * {{R_WIDTH{1'b0}}, ady_i};
      x_q     <= x_i;
      y_q     <= y_i;
    end
  end

  assign valid_o = valid_q;
  assign dx_sq_o = dx_sq_q;
  assign dy_sq_o = dy_sq_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
endmodule

// File: rtl/painter_multi.sv
// painter_multi: rasterises a filled disc or ring around a centre point,
// clipped to the screen, emitting one candidate per cycle through
// S0 scan counter -> S1 squares -> S2 compare -> S3 output register.
//   clk_in, rst_in - clock, synchronous active-high reset
//   bus (slave)    - request handshake, pixel stream, done pulse, shape count
//
//   state | meaning
//   IDLE  | ready_out high, waiting for a request
//   SCAN  | S0 walks the clipped box in raster order
//   DRAIN | box exhausted, waiting for S1..S3 to empty
import painter_pkg::*;

module painter_multi #(
  parameter int H_WIDTH     = H_WIDTH_DEF,
  parameter int V_WIDTH     = V_WIDTH_DEF,
  parameter int R_WIDTH     = R_WIDTH_DEF,
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF,
  parameter int H_MAX       = H_MAX_DEF,
  parameter int V_MAX       = V_MAX_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  painter_multi_if.slave bus
);
  localparam int CW = max_int(H_WIDTH, V_WIDTH) + 2;
  localparam int DW = 2*R_WIDTH + 1;
  localparam logic signed [CW-1:0] X_LAST = CW'(H_MAX - 1);
  localparam logic signed [CW-1:0] Y_LAST = CW'(V_MAX - 1);

  painter_state_t state_q, state_d;
  logic accept_c, stall_c, done_c, s0_v_c, s0_last_c;

  logic [H_WIDTH-1:0]     cx_q, xs_q, xe_q, x_q;
  logic [V_WIDTH-1:0]     cy_q, ye_q, y_q;
  logic [COLOR_WIDTH-1:0] color_q;
  logic                   ring_q;
  logic [2*R_WIDTH-1:0]   rr_q, inner_q;
  logic [15:0]            shape_cnt_q;

  // request decode: clipped box and distance thresholds
  logic signed [CW-1:0] cx_s, cy_s, r_s;
  logic signed [CW-1:0] bx_lo, bx_hi, by_lo, by_hi, bxs, bxe, bys, bye;
  logic                 box_off_c, ring_c;
  logic [R_WIDTH-1:0]   t_eff_c, d_in_c;
  logic [2*R_WIDTH-1:0] rr_c, inner_c;

  always_comb begin
    cx_s  = $signed({{(CW-H_WIDTH){1'b0}}, bus.hcount_in});
    cy_s  = $signed({{(CW-V_WIDTH){1'b0}}, bus.vcount_in});
    r_s   = $signed({{(CW-R_WIDTH){1'b0}}, bus.radius_in});
    bx_lo = cx_s - r_s;
    bx_hi = cx_s + r_s;
    by_lo = cy_s - r_s;
    by_hi = cy_s + r_s;
    bxs   = (bx_lo < 0) ? '0 : bx_lo;
    bxe   = (bx_hi > X_LAST) ? X_LAST : bx_hi;
    bys   = (by_lo < 0) ? '0 : by_lo;
    bye   = (by_hi > Y_LAST) ? Y_LAST : by_hi;
    box_off_c = (bxs > bxe) || (bys > bye);

    // thickness 0 behaves as 1; a ring thicker than its radius is a disc
    t_eff_c = (bus.thickness_in == '0) ? R_WIDTH'(1) : bus.thickness_in;
    ring_c  = (paint_mode_t'(bus.mode_in) == RING) && (t_eff_c <= bus.radius_in);
    d_in_c  = bus.radius_in - t_eff_c;
    rr_c    = {{R_WIDTH{1'b0}}, bus.radius_in} * {{R_WIDTH{1'b0}}, bus.radius_in};
    inner_c = ring_c ? ({{R_WIDTH{1'b0}}, d_in_c} * {{R_WIDTH{1'b0}}, d_in_c}) : '0;
  end

  // S0: distances are within the box, so they fit R_WIDTH
  logic [R_WIDTH-1:0] adx_c, ady_c;
  assign adx_c = R_WIDTH'((x_q >= cx_q) ? (x_q - cx_q) : (cx_q - x_q));
  assign ady_c = R_WIDTH'((y_q >= cy_q) ? (y_q - cy_q) : (cy_q - y_q));

  logic                 s1_v;
  logic [2*R_WIDTH-1:0] s1_dx_sq, s1_dy_sq;
  logic [H_WIDTH-1:0]   s1_x;
  logic [V_WIDTH-1:0]   s1_y;

  sq_dist #(.R_WIDTH(R_WIDTH), .H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_sq_dist (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .stall_i (stall_c),
    .valid_i (s0_v_c),
    .adx_i   (adx_c),
    .ady_i   (ady_c),
    .x_i     (x_q),
    .y_i     (y_q),
    .valid_o (s1_v),
    .dx_sq_o (s1_dx_sq),
    .dy_sq_o (s1_dy_sq),
    .x_o     (s1_x),
    .y_o     (s1_y)
  );

  // S2 compare
  logic [DW-1:0] d2_c;
  logic          hit_c;
  assign d2_c  = DW'(s1_dx_sq) + DW'(s1_dy_sq);
  assign hit_c = (d2_c <= DW'(rr_q)) && (!ring_q || (d2_c > DW'(inner_q)));

  logic                   s2_v_q, s2_hit_q;
  logic [H_WIDTH-1:0]     s2_x_q, hout_q;
  logic [V_WIDTH-1:0]     s2_y_q, vout_q;
  logic                   dvo_q;
  logic [COLOR_WIDTH-1:0] cout_q;

  assign accept_c  = (state_q == IDLE) && bus.data_valid_in;
  assign stall_c   = dvo_q && !bus.ready_in;
  assign s0_v_c    = (state_q == SCAN);
  assign s0_last_c = (x_q == xe_q) && (y_q == ye_q);

  always_comb begin
    state_d = state_q;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.data_valid_in) state_d = box_off_c ? DRAIN : SCAN;
      SCAN:  if (!stall_c && s0_last_c) state_d = DRAIN;
      DRAIN: if (!s1_v && !s2_v_q && !dvo_q) begin
               state_d = IDLE;
               done_c  = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cx_q <= '0; cy_q <= '0; xs_q <= '0; xe_q <= '0; ye_q <= '0;
      x_q <= '0; y_q <= '0; color_q <= '0; ring_q <= 1'b0;
      rr_q <= '0; inner_q <= '0; shape_cnt_q <= '0;
      s2_v_q <= 1'b0; s2_hit_q <= 1'b0; s2_x_q <= '0; s2_y_q <= '0;
      dvo_q <= 1'b0; hout_q <= '0; vout_q <= '0; cout_q <= '0;
    end else begin
      if (done_c) shape_cnt_q <= shape_cnt_q + 16'd1;

      if (accept_c) begin
        cx_q    <= bus.hcount_in;
        cy_q    <= bus.vcount_in;
        color_q <= bus.color_in;
        ring_q  <= ring_c;
        rr_q    <= rr_c;
        inner_q <= inner_c;
        xs_q    <= H_WIDTH'(bxs);
        xe_q    <= H_WIDTH'(bxe);
        ye_q    <= V_WIDTH'(bye);
        x_q     <= H_WIDTH'(bxs);
        y_q     <= V_WIDTH'(bys);
      end else if (s0_v_c && !stall_c) begin
        if (x_q == xe_q) begin
          x_q <= xs_q;
          y_q <= y_q + V_WIDTH'(1);
        end else begin
          x_q <= x_q + H_WIDTH'(1);
        end
      end

      if (!stall_c) begin
        s2_v_q   <= s1_v;
        s2_hit_q <= hit_c;
        s2_x_q   <= s1_x;
        s2_y_q   <= s1_y;
        dvo_q    <= s2_v_q && s2_hit_q;
        hout_q   <= s2_x_q;
        vout_q   <= s2_y_q;
        cout_q   <= color_q;
      end
    end
  end

  assign bus.ready_out       = (state_q == IDLE);
  assign bus.done_out        = done_c;
  assign bus.data_valid_out  = dvo_q;
  assign bus.hcount_out      = hout_q;
  assign bus.vcount_out      = vout_q;
  assign bus.color_out       = cout_q;
  assign bus.shape_count_out = shape_cnt_q;
endmodule
